// File: rtl/ddr3_cmd_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_bus_arbiter_pkg
//
// Shared types and constants for the DDR3 command arbiter slice.
//
// Contents:
//   NUM_BANKS, ROW_W, BA_W  - bank count, address bus width, bank-address width
//   ddr3_cmd_t              - command requested by a bank FSM or the refresh FSM
//   bank_t                  - bank index / round-robin pointer
//   PINS_*                  - {CS#, RAS#, CAS#, WE#} pin patterns per command
//   ddr3_encode_cmd()       - maps a command onto its pin pattern
// ---------------------------------------------------------------------------
package ddr3_cmd_bus_arbiter_pkg;

    localparam int NUM_BANKS = 4;
    localparam int ROW_W     = 13;
    localparam int BA_W      = 3;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } ddr3_cmd_t;

    typedef enum logic [1:0] {
        BANK0 = 2'd0,
        BANK1 = 2'd1,
        BANK2 = 2'd2,
        BANK3 = 2'd3
    } bank_t;

    // Pin patterns ordered {CS#, RAS#, CAS#, WE#}
    localparam logic [3:0] PINS_NOP = 4'b0111;
    localparam logic [3:0] PINS_ACT = 4'b0011;
    localparam logic [3:0] PINS_RD  = 4'b0101;
    localparam logic [3:0] PINS_WR  = 4'b0100;
    localparam logic [3:0] PINS_PRE = 4'b0010;
    localparam logic [3:0] PINS_REF = 4'b0001;

    // Encodings outside the enum (values 6 and 7) fall back to NOP so a
    // corrupted request can never put an unintended command on the bus.
    function automatic logic [3:0] ddr3_encode_cmd(input ddr3_cmd_t cmd);
        logic [3:0] pins;
        case (cmd)
            NOP:     pins = PINS_NOP;
            ACT:     pins = PINS_ACT;
            RD:      pins = PINS_RD;
            WR:      pins = PINS_WR;
            PRE:     pins = PINS_PRE;
            REF:     pins = PINS_REF;
            default: pins = PINS_NOP;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/ddr3_cmd_bus_arbiter_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_bus_arbiter_rr_arbiter4
//
// Purely combinational 4-way round-robin arbiter. The search starts at
// `pointer` and wraps modulo 4; the first requesting bank wins.
//
// Ports:
//   request [3:0]  in   one bit per bank, 1 = bank wants the bus
//   pointer        in   bank with the highest priority this cycle
//   grant   [3:0]  out  one-hot grant, all zero when nothing requests
//   index          out  index of the granted bank, BANK0 when none
//   valid          out  1 when some bank was granted
// ---------------------------------------------------------------------------
module ddr3_cmd_bus_arbiter_rr_arbiter4
    import ddr3_cmd_bus_arbiter_pkg::*;
(
    input  logic [NUM_BANKS-1:0] request,
    input  bank_t                pointer,
    output logic [NUM_BANKS-1:0] grant,
    output bank_t                index,
    output logic                 valid
);

    logic [1:0] candidate;

    // The 2-bit candidate index wraps naturally, giving the modulo-4 walk
    // from the pointer without any explicit compare.
    always_comb begin
        grant     = '0;
        index     = BANK0;
        valid     = 1'b0;
        candidate = 2'd0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            candidate = pointer + 2'(k);
            if (!valid && request[candidate]) begin
                valid            = 1'b1;
                index            = bank_t'(candidate);
                grant[candidate] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_cmd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_bus_arbiter
//
// Command arbiter and encoder between the four bank FSMs, the refresh FSM
// and the DDR3 command/address pins. Refresh always wins; otherwise the
// eligible banks are served round-robin. The winning command is encoded and
// registered onto the pins, so it appears one clock after the grant.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   bank_cmd_valid [3:0] per-bank request
//   bank_cmd_type  [3:0] per-bank requested command
//   bank_addr      [3:0] per-bank row / column / A10 address
//   refresh_req          refresh FSM wants a REF this cycle
//   bank_cmd_grant [3:0] one-hot combinational grant
//   refresh_ack          combinational REF acceptance
//   ddr3_cs_n/ras_n/cas_n/we_n, ddr3_ba, ddr3_addr   registered pins
//   prio_bank            current round-robin pointer (registered)
//   sel_bank             bank chosen this cycle, BANK0 when none
//   bank_selected        combinational: a bank command won this cycle
// ---------------------------------------------------------------------------
module ddr3_cmd_bus_arbiter
    import ddr3_cmd_bus_arbiter_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic      [NUM_BANKS-1:0]           bank_cmd_valid,
    input  ddr3_cmd_t [NUM_BANKS-1:0]           bank_cmd_type,
    input  logic      [NUM_BANKS-1:0][ROW_W-1:0] bank_addr,
    input  logic                                refresh_req,
    output logic      [NUM_BANKS-1:0]           bank_cmd_grant,
    output logic                                refresh_ack,
    output logic                                ddr3_cs_n,
    output logic                                ddr3_ras_n,
    output logic                                ddr3_cas_n,
    output logic                                ddr3_we_n,
    output logic      [BA_W-1:0]                ddr3_ba,
    output logic      [ROW_W-1:0]               ddr3_addr,
    output bank_t                               prio_bank,
    output bank_t                               sel_bank,
    output logic                                bank_selected
);

    logic [NUM_BANKS-1:0] eligible;
    logic [NUM_BANKS-1:0] arb_request;
    logic [NUM_BANKS-1:0] arb_grant;
    bank_t                arb_index;
    logic                 arb_valid;

    logic [3:0]           next_pins;
    logic [BA_W-1:0]      next_ba;
    logic [ROW_W-1:0]     next_addr;
    bank_t                next_prio;

    // A NOP request does not compete for the bus. Out-of-range encodings
    // still compete (and get granted) so the bank FSM is not stalled forever.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            eligible[i] = bank_cmd_valid[i] && (bank_cmd_type[i] != NOP);
        end
    end

    // Masking the requests during refresh keeps grants at zero and leaves
    // the pointer untouched, so banks resume exactly where they left off.
    assign arb_request = refresh_req ? '0 : eligible;

    ddr3_cmd_bus_arbiter_rr_arbiter4 u_rr_arbiter (
        .request (arb_request),
        .pointer (prio_bank),
        .grant   (arb_grant),
        .index   (arb_index),
        .valid   (arb_valid)
    );

    assign bank_cmd_grant = arb_grant;
    assign refresh_ack    = refresh_req;
    assign bank_selected  = arb_valid;
    assign sel_bank       = arb_valid ? arb_index : BANK0;

    // Build the command for the next edge: REF, the winning bank's command,
    // or an idle NOP with a zeroed address bus.
    always_comb begin
        next_pins = PINS_NOP;
        next_ba   = '0;
        next_addr = '0;
        next_prio = prio_bank;
        if (refresh_req) begin
            next_pins = ddr3_encode_cmd(REF);
        end else if (arb_valid) begin
            next_pins = ddr3_encode_cmd(bank_cmd_type[arb_index]);
            next_ba   = {1'b0, arb_index};
            next_addr = bank_addr[arb_index];
            next_prio = bank_t'(arb_index + 2'd1);
        end
    end

    // Pins and pointer share one register stage; reset drives NOP onto the
    // bus asynchronously so the DRAM never sees a stale command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= PINS_NOP;
            ddr3_ba   <= '0;
            ddr3_addr <= '0;
            prio_bank <= BANK0;
        end else begin
            {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= next_pins;
            ddr3_ba   <= next_ba;
            ddr3_addr <= next_addr;
            prio_bank <= next_prio;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_cmd_bus_arbiter
//
// Self-checking bench for ddr3_cmd_bus_arbiter. Directed scenarios cover
// reset, a single bank, round-robin rotation, refresh priority, NOP
// filtering, out-of-range command values and asynchronous reset; a random
// phase compares every cycle against a behavioural model of the arbitration
// rules. Inputs change 1 time unit after a rising edge, combinational outputs
// are sampled on the falling edge, registered outputs 1 unit after the edge.
// ---------------------------------------------------------------------------
module tb_ddr3_cmd_bus_arbiter;
    import ddr3_cmd_bus_arbiter_pkg::*;

    logic                                 clk;
    logic                                 rst;
    logic      [NUM_BANKS-1:0]            valid;
    ddr3_cmd_t [NUM_BANKS-1:0]            types;
    logic      [NUM_BANKS-1:0][ROW_W-1:0] addrs;
    logic                                 refresh;

    logic [NUM_BANKS-1:0] grant;
    logic                 ack;
    logic                 cs_n, ras_n, cas_n, we_n;
    logic [BA_W-1:0]      ba;
    logic [ROW_W-1:0]     addr;
    bank_t                prio;
    bank_t                sel;
    logic                 bsel;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state and per-cycle expectations
    logic [1:0]           m_ptr;
    logic [NUM_BANKS-1:0] exp_grant;
    logic                 exp_ack;
    logic                 exp_bsel;
    logic [1:0]           exp_sel;
    logic [3:0]           exp_pins;
    logic [BA_W-1:0]      exp_ba;
    logic [ROW_W-1:0]     exp_addr;
    logic [1:0]           exp_next;

    ddr3_cmd_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .bank_cmd_valid (valid),
        .bank_cmd_type  (types),
        .bank_addr      (addrs),
        .refresh_req    (refresh),
        .bank_cmd_grant (grant),
        .refresh_ack    (ack),
        .ddr3_cs_n      (cs_n),
        .ddr3_ras_n     (ras_n),
        .ddr3_cas_n     (cas_n),
        .ddr3_we_n      (we_n),
        .ddr3_ba        (ba),
        .ddr3_addr      (addr),
        .prio_bank      (prio),
        .sel_bank       (sel),
        .bank_selected  (bsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // DDR3 truth table {CS#, RAS#, CAS#, WE#}
    function automatic logic [3:0] pins_of(input int cmd);
        case (cmd)
            1:       return 4'b0011;
            2:       return 4'b0101;
            3:       return 4'b0100;
            4:       return 4'b0010;
            5:       return 4'b0001;
            default: return 4'b0111;
        endcase
    endfunction

    // Arbitration rules: REF first, else first eligible bank counting up from
    // the pointer modulo 4; idle cycles issue NOP with zero address.
    task automatic compute_expected();
        int  b;
        bit  found;
        exp_ack   = refresh;
        exp_grant = '0;
        exp_bsel  = 1'b0;
        exp_sel   = 2'd0;
        exp_pins  = 4'b0111;
        exp_ba    = '0;
        exp_addr  = '0;
        exp_next  = m_ptr;
        found     = 1'b0;
        if (refresh) begin
            exp_pins = 4'b0001;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                b = (int'(m_ptr) + k) % NUM_BANKS;
                if (!found && valid[b] && int'(types[b]) != 0) begin
                    found        = 1'b1;
                    exp_grant[b] = 1'b1;
                    exp_bsel     = 1'b1;
                    exp_sel      = 2'(b);
                    exp_pins     = pins_of(int'(types[b]));
                    exp_ba       = 3'(b);
                    exp_addr     = addrs[b];
                    exp_next     = 2'((b + 1) % NUM_BANKS);
                end
            end
        end
    endtask

    task automatic clear_inputs();
        valid   = '0;
        refresh = 1'b0;
        addrs   = '0;
        for (int i = 0; i < NUM_BANKS; i++) types[i] = NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111) begin
            n_fail++;
            $display("[TB] FAIL reset_pins: got %b expected 0111", {cs_n, ras_n, cas_n, we_n});
        end
        n_checks++;
        if (ba !== 3'd0 || addr !== 13'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_ba_addr: got ba=%0d addr=%h expected 0/0", ba, addr);
        end
        n_checks++;
        if (prio !== BANK0) begin
            n_fail++;
            $display("[TB] FAIL reset_prio: got %0d expected 0", prio);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_ptr = 2'd0;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || grant !== 4'b0000 || ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: pins=%b grant=%b ack=%b expected 0111/0000/0",
                     {cs_n, ras_n, cas_n, we_n}, grant, ack);
        end
    endtask

    task automatic test_single_bank();
        valid    = 4'b0010;
        types[1] = ACT;
        addrs[1] = 13'h100;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010 || bsel !== 1'b1 || sel !== BANK1 || ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_grant: grant=%b bsel=%b sel=%0d ack=%b expected 0010/1/1/0",
                     grant, bsel, sel, ack);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0011 || ba !== 3'd1 || addr !== 13'h100) begin
            n_fail++;
            $display("[TB] FAIL single_pins: pins=%b ba=%0d addr=%h expected 0011/1/100",
                     {cs_n, ras_n, cas_n, we_n}, ba, addr);
        end
        n_checks++;
        if (prio !== BANK2) begin
            n_fail++;
            $display("[TB] FAIL single_prio: got %0d expected 2", prio);
        end
        m_ptr = 2'd2;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int b;
        // Bank 3 alone moves the pointer back to BANK0
        valid    = 4'b1000;
        types[3] = RD;
        @(posedge clk);
        #1;
        n_checks++;
        if (prio !== BANK0) begin
            n_fail++;
            $display("[TB] FAIL rr_wrap_prio: got %0d expected 0", prio);
        end
        valid = 4'b1111;
        for (int i = 0; i < NUM_BANKS; i++) begin
            types[i] = RD;
            addrs[i] = 13'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            b = i % NUM_BANKS;
            @(negedge clk);
            n_checks++;
            if (grant !== 4'(1 << b) || sel !== bank_t'(b)) begin
                n_fail++;
                $display("[TB] FAIL rr_grant[%0d]: grant=%b sel=%0d expected %b/%0d",
                         i, grant, sel, 4'(1 << b), b);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({cs_n, ras_n, cas_n, we_n} !== 4'b0101 || ba !== 3'(b) || addr !== addrs[b]) begin
                n_fail++;
                $display("[TB] FAIL rr_pins[%0d]: pins=%b ba=%0d addr=%h expected 0101/%0d/%h",
                         i, {cs_n, ras_n, cas_n, we_n}, ba, addr, b, addrs[b]);
            end
        end
        m_ptr = 2'd0;
        clear_inputs();
    endtask

    task automatic test_refresh_priority();
        valid    = 4'b0101;
        types[0] = PRE;
        types[2] = PRE;
        addrs[0] = 13'h400;
        addrs[2] = 13'h1abc;
        refresh  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1 || grant !== 4'b0000 || bsel !== 1'b0 || sel !== BANK0) begin
            n_fail++;
            $display("[TB] FAIL ref_comb: ack=%b grant=%b bsel=%b sel=%0d expected 1/0000/0/0",
                     ack, grant, bsel, sel);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0001 || ba !== 3'd0 || addr !== 13'd0) begin
            n_fail++;
            $display("[TB] FAIL ref_pins: pins=%b ba=%0d addr=%h expected 0001/0/0",
                     {cs_n, ras_n, cas_n, we_n}, ba, addr);
        end
        n_checks++;
        if (prio !== bank_t'(m_ptr)) begin
            n_fail++;
            $display("[TB] FAIL ref_prio_hold: got %0d expected %0d", prio, m_ptr);
        end
        refresh = 1'b0;
        compute_expected();
        @(negedge clk);
        n_checks++;
        if (grant !== exp_grant || ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ref_resume_grant: grant=%b ack=%b expected %b/0", grant, ack, exp_grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0010 || ba !== exp_ba || addr !== exp_addr
            || prio !== bank_t'(exp_next)) begin
            n_fail++;
            $display("[TB] FAIL ref_resume_pins: pins=%b ba=%0d addr=%h prio=%0d expected 0010/%0d/%h/%0d",
                     {cs_n, ras_n, cas_n, we_n}, ba, addr, prio, exp_ba, exp_addr, exp_next);
        end
        m_ptr = exp_next;
        clear_inputs();
    endtask

    task automatic test_nop_filter();
        valid = 4'b1111;
        for (int i = 0; i < NUM_BANKS; i++) begin
            types[i] = NOP;
            addrs[i] = 13'h0fff;
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000 || bsel !== 1'b0 || sel !== BANK0 || ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nop_grant: grant=%b bsel=%b sel=%0d ack=%b expected 0000/0/0/0",
                     grant, bsel, sel, ack);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || ba !== 3'd0 || addr !== 13'd0
            || prio !== bank_t'(m_ptr)) begin
            n_fail++;
            $display("[TB] FAIL nop_pins: pins=%b ba=%0d addr=%h prio=%0d expected 0111/0/0/%0d",
                     {cs_n, ras_n, cas_n, we_n}, ba, addr, prio, m_ptr);
        end
        clear_inputs();
    endtask

    task automatic test_invalid_enum();
        valid    = 4'b0100;
        types[2] = ddr3_cmd_t'(3'd6);
        addrs[2] = 13'h0055;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0100 || bsel !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL invalid_grant: grant=%b bsel=%b expected 0100/1", grant, bsel);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || prio !== BANK3) begin
            n_fail++;
            $display("[TB] FAIL invalid_pins: pins=%b prio=%0d expected 0111/3",
                     {cs_n, ras_n, cas_n, we_n}, prio);
        end
        m_ptr = 2'd3;
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            refresh = ($urandom_range(0, 4) == 0);
            valid   = 4'($urandom);
            for (int i = 0; i < NUM_BANKS; i++) begin
                types[i] = ddr3_cmd_t'(3'($urandom_range(0, 5)));
                addrs[i] = 13'($urandom);
            end
            compute_expected();
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant || ack !== exp_ack || bsel !== exp_bsel || sel !== bank_t'(exp_sel)) begin
                n_fail++;
                $display("[TB] FAIL rand_comb[%0d]: grant=%b ack=%b bsel=%b sel=%0d expected %b/%b/%b/%0d",
                         n, grant, ack, bsel, sel, exp_grant, exp_ack, exp_bsel, exp_sel);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({cs_n, ras_n, cas_n, we_n} !== exp_pins || ba !== exp_ba || addr !== exp_addr
                || prio !== bank_t'(exp_next)) begin
                n_fail++;
                $display("[TB] FAIL rand_pins[%0d]: pins=%b ba=%0d addr=%h prio=%0d expected %b/%0d/%h/%0d",
                         n, {cs_n, ras_n, cas_n, we_n}, ba, addr, prio, exp_pins, exp_ba, exp_addr, exp_next);
            end
            m_ptr = exp_next;
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        valid = 4'b1111;
        for (int i = 0; i < NUM_BANKS; i++) begin
            types[i] = WR;
            addrs[i] = 13'($urandom) | 13'h1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL burst_pins: got %b expected 0100", {cs_n, ras_n, cas_n, we_n});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || ba !== 3'd0 || addr !== 13'd0 || prio !== BANK0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: pins=%b ba=%0d addr=%h prio=%0d expected 0111/0/0/0",
                     {cs_n, ras_n, cas_n, we_n}, ba, addr, prio);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_ptr = 2'd0;
    endtask

    initial begin
        m_ptr = 2'd0;
        test_reset();
        test_single_bank();
        test_round_robin();
        test_refresh_priority();
        test_nop_filter();
        test_invalid_enum();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
